// File: rtl/e1_tx_wb.sv
// e1_tx_wb: Wishbone control top for one E1 transmitter, BD-in/BD-out FIFOs, underflow flag and irq.
// Build option: define E1_TX_IRQ_MASK_EN to add irq source masks at CSR 0x0 bits [5:4].

module fifo_sync_shift #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] di,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  mem_n [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wp;
    logic          wr_ok, rd_ok;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;
    assign dout  = mem[0];
    // With a simultaneous pop the free slot is one below the current count.
    assign wp    = AW'(rd_ok ? cnt - 1'b1 : cnt);

    always_comb begin
        mem_n = mem;
        if (rd_ok)
            for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
        if (wr_ok) mem_n[wp] = di;
    end

    always_ff @(posedge clk) mem <= mem_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (clr)           cnt <= '0;
        else if (wr_ok & ~rd_ok) cnt <= cnt + 1'b1;
        else if (rd_ok & ~wr_ok) cnt <= cnt - 1'b1;
    end
endmodule

module e1_tx_wb #(
    parameter int MFW = 7
) (
    input  logic           clk,
    input  logic           rst,
    output logic           pad_tx_hi,
    output logic           pad_tx_lo,
    input  logic [7:0]     buf_tx_data,
    output logic [4:0]     buf_tx_ts,
    output logic [3:0]     buf_tx_frame,
    output logic [MFW-1:0] buf_tx_mf,
    output logic           buf_tx_re,
    input  logic           buf_tx_rdy,
    input  logic [3:0]     bus_addr,
    input  logic [15:0]    bus_wdata,
    output logic [15:0]    bus_rdata,
    input  logic           bus_cyc,
    input  logic           bus_we,
    output logic           bus_ack,
    output logic           irq,
    output logic           tick_tx
);
    logic           enabled, alarm, underflow;
    logic [1:0]     mode;
    logic           mask_underflow, mask_bdout;
    logic           tx_rst, tx_rst_d, fifo_clr;
    logic           wr_csr_stb, clr_stb, bi_push_stb, bo_pop_stb;
    logic           bi_full, bi_empty, bo_full, bo_empty;
    logic [MFW-1:0] bi_do, bo_do;
    logic           bd_done, bd_miss;
    logic           req;
    logic [15:0]    csr_status, rd_val;
    logic           unused_wdata;

    assign req          = bus_cyc & ~bus_ack;
    assign unused_wdata = ^bus_wdata;

`ifdef E1_TX_IRQ_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_underflow <= 1'b0;
            mask_bdout     <= 1'b0;
        end else if (wr_csr_stb) begin
            mask_underflow <= bus_wdata[5];
            mask_bdout     <= bus_wdata[4];
        end
    end
`else
    assign mask_underflow = 1'b0;
    assign mask_bdout     = 1'b0;
`endif

    assign csr_status = {3'b0, underflow, bo_full, bo_empty, bi_full, bi_empty,
                         2'b0, mask_underflow, mask_bdout, alarm, mode, enabled};

    always_comb begin
        rd_val = 16'h0000;
        case (bus_addr)
            4'h0: rd_val = csr_status;
            4'h2: if (!bo_empty) rd_val = {1'b1, {(15-MFW){1'b0}}, bo_do};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ack     <= 1'b0;
            bus_rdata   <= 16'h0000;
            wr_csr_stb  <= 1'b0;
            clr_stb     <= 1'b0;
            bi_push_stb <= 1'b0;
            bo_pop_stb  <= 1'b0;
        end else begin
            bus_ack     <= req;
            bus_rdata   <= (req & ~bus_we) ? rd_val : 16'h0000;
            wr_csr_stb  <= req & bus_we & (bus_addr == 4'h0);
            clr_stb     <= req & bus_we & (bus_addr == 4'h0) & bus_wdata[12];
            bi_push_stb <= req & bus_we & (bus_addr == 4'h2) & ~bi_full;
            bo_pop_stb  <= req & ~bus_we & (bus_addr == 4'h2) & ~bo_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enabled   <= 1'b0;
            mode      <= 2'b00;
            alarm     <= 1'b0;
            underflow <= 1'b0;
            irq       <= 1'b0;
            tx_rst    <= 1'b1;
            tx_rst_d  <= 1'b1;
        end else begin
            if (wr_csr_stb) begin
                enabled <= bus_wdata[0];
                mode    <= bus_wdata[2:1];
                alarm   <= bus_wdata[3];
            end
            underflow <= (underflow & ~clr_stb) | bd_miss | (bd_done & bo_full);
            irq       <= (~bo_empty & ~mask_bdout) | (underflow & ~mask_underflow);
            tx_rst    <= ~enabled;
            tx_rst_d  <= tx_rst;
        end
    end

    // Flush only on the disable edge so descriptors can be queued while the core is idle.
    assign fifo_clr = tx_rst & ~tx_rst_d;

    fifo_sync_shift #(.W(MFW), .DEPTH(4)) u_bi (
        .clk(clk), .rst(rst), .clr(fifo_clr), .wr(bi_push_stb), .rd(bd_done),
        .di(bus_wdata[MFW-1:0]), .dout(bi_do), .full(bi_full), .empty(bi_empty)
    );

    fifo_sync_shift #(.W(MFW), .DEPTH(4)) u_bo (
        .clk(clk), .rst(rst), .clr(fifo_clr), .wr(bd_done & ~bo_full), .rd(bo_pop_stb),
        .di(bi_do), .dout(bo_do), .full(bo_full), .empty(bo_empty)
    );

    logic [2:0]     bit_cnt;
    logic [4:0]     ts;
    logic [3:0]     frame;
    logic [MFW-1:0] cur_mf, fetch_mf;
    logic           cur_valid, fetch_valid, pos0, pol, alarm_q, line_bit;
    logic [1:0]     mode_q;
    logic [7:0]     nxt, sh, slot_byte;

    // The BD for a multiframe is taken from the BD-in head at its first fetch slot.
    assign pos0        = (bit_cnt == 3'd0) && (ts == 5'd0) && (frame == 4'd0);
    assign bd_miss     = pos0 & ~tx_rst & bi_empty;
    assign fetch_valid = pos0 ? ~bi_empty : cur_valid;
    assign fetch_mf    = pos0 ? bi_do : cur_mf;
    assign line_bit    = alarm_q | sh[7];

    always_comb begin
        slot_byte = (cur_valid & buf_tx_rdy) ? buf_tx_data : 8'hFF;
        if (mode_q[1] && buf_tx_ts != 5'd0) slot_byte = 8'hD5;
        if (mode_q[0] && buf_tx_ts == 5'd0) slot_byte = buf_tx_frame[0] ? 8'h40 : 8'h1B;
    end

    always_ff @(posedge clk) begin
        if (bit_cnt == 3'd0) begin
            buf_tx_ts    <= ts;
            buf_tx_frame <= frame;
            buf_tx_mf    <= fetch_mf;
        end
        if (pos0) cur_mf <= bi_do;
        if (bit_cnt == 3'd2) nxt <= slot_byte;
    end

    // Line output trails the fetch counter by one timeslot (AMI coded).
    always_ff @(posedge clk or posedge tx_rst) begin
        if (tx_rst) begin
            {frame, ts, bit_cnt} <= 12'd0;
            cur_valid <= 1'b0;
            mode_q    <= 2'b00;
            alarm_q   <= 1'b0;
            sh        <= 8'h00;
            pol       <= 1'b0;
            buf_tx_re <= 1'b0;
            tick_tx   <= 1'b0;
            bd_done   <= 1'b0;
            pad_tx_hi <= 1'b0;
            pad_tx_lo <= 1'b0;
        end else begin
            {frame, ts, bit_cnt} <= {frame, ts, bit_cnt} + 12'd1;
            if (pos0) cur_valid <= ~bi_empty;
            buf_tx_re <= (bit_cnt == 3'd0) & fetch_valid;
            if (ts == 5'd31 && bit_cnt == 3'd7) begin
                mode_q  <= mode;
                alarm_q <= alarm;
            end
            tick_tx   <= (ts == 5'd31) && (bit_cnt == 3'd6);
            bd_done   <= (frame == 4'd15) && (ts == 5'd31) && (bit_cnt == 3'd6) && cur_valid;
            sh        <= (bit_cnt == 3'd7) ? nxt : {sh[6:0], 1'b0};
            pad_tx_hi <= line_bit & ~pol;
            pad_tx_lo <= line_bit & pol;
            if (line_bit) pol <= ~pol;
        end
    end
endmodule
